program_memory_loader: RTL and testbench

//  Write-side counterpart of the instruction ROM: loads a program into program memory at run time.

---
 rtl/program_memory_loader_pkg.sv | 15 +
 rtl/program_memory_loader_if.sv | 34 +++
 rtl/program_memory_loader_packer.sv | 45 ++++
 rtl/program_memory_loader.sv | 122 ++++++++++++
 tb/tb_program_memory_loader.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/program_memory_loader_pkg.sv
// Shared types and constants for the program memory loader.
// State encoding and byte/word geometry.
package mips_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_WIDTH     = 8;

endpackage

// File: rtl/program_memory_loader_if.sv
// Byte stream handshake plus program memory write bus.
// The loader is the slave side; the host/bench is the master.
interface program_memory_loader_if
  import mips_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
);

  logic                  byte_valid_i;
  logic [BYTE_WIDTH-1:0] byte_data_i;
  logic                  byte_ready_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_data_o;

  modport slave (
    input  byte_valid_i,
    input  byte_data_i,
    output byte_ready_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_data_o
  );

  modport master (
    output byte_valid_i,
    output byte_data_i,
    input  byte_ready_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_data_o
  );

endinterface

// File: rtl/program_memory_loader_packer.sv
// Big-endian 8->32 shift register with a byte counter.
// word_out includes the byte being shifted in this cycle.
module byte_word_packer
  import mips_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  shift_en,
  input  logic [BYTE_WIDTH-1:0] byte_in,
  output logic [31:0]           word_out,
  output logic                  word_full
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_en) begin
      word_d = {word_q[23:0], byte_in};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  assign word_out  = word_d;
  assign word_full = shift_en && !clear && (cnt_q == LAST_BYTE);

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/program_memory_loader.sv
// Loads a byte stream into program memory one word at a time,
// holding the core in reset until the load completes.
module program_memory_loader
  import mips_loader_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = '0,
  parameter int                    CNT_WIDTH    = $clog2(MEMORY_DEPTH) + 1
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] word_count_i,
  program_memory_loader_if.slave bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic                 cpu_hold_o
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(MEMORY_DEPTH);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  index_q, index_d;
  logic [CNT_WIDTH-1:0]  index_inc;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, ready_q, busy_q, done_q;

  logic        clear, shift_en, word_full;
  logic        start_ok, cnt_ok;
  logic [31:0] word;

  byte_word_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .shift_en  (shift_en),
    .byte_in   (bus.byte_data_i),
    .word_out  (word),
    .word_full (word_full)
  );

  assign index_inc = index_q + CNT_WIDTH'(1);
  assign start_ok  = start_i && (state_q == IDLE || state_q == DONE);
  assign cnt_ok    = (word_count_i != '0) && (word_count_i <= DEPTH_C);
  assign shift_en  = (state_q == RECV) && bus.byte_valid_i;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    error_d = error_q;
    addr_d  = addr_q;
    data_d  = data_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_ok && cnt_ok) begin
          state_d = RECV;
          count_d = word_count_i;
          index_d = '0;
          error_d = 1'b0;
          clear   = 1'b1;
        end else if (start_ok) begin
          error_d = 1'b1;
        end
      end
      RECV: begin
        if (word_full) begin
          state_d = WRITE;
          addr_d  = BASE_ADDRESS + (DATA_WIDTH'(index_q) << 2);
          data_d  = DATA_WIDTH'(word);
        end
      end
      WRITE: begin
        index_d = index_inc;
        state_d = (index_inc == count_q) ? DONE : RECV;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      index_q <= '0;
      error_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      index_q <= index_d;
      error_q <= error_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= (state_d == WRITE);
      ready_q <= (state_d == RECV);
      busy_q  <= (state_d == RECV) || (state_d == WRITE);
      done_q  <= (state_d == DONE);
    end
  end

  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;
  assign bus.byte_ready_o = ready_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign error_o          = error_q;
  assign cpu_hold_o       = busy_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// Bench for program_memory_loader: two instances (base 0 and
// base 0x0040_0000) share one byte stream; writes go through a scoreboard.
module tb_program_memory_loader;
  import mips_loader_pkg::*;

  localparam int          CW    = 6;
  localparam logic [31:0] BASE1 = 32'h0040_0000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start_i = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic          bv = 1'b0;
  logic [7:0]    bd = 8'h00;
  logic          busy0, done0, err0, hold0;
  logic          busy1, done1, err1, hold1;

  program_memory_loader_if #(.DATA_WIDTH(32)) bus0 ();
  program_memory_loader_if #(.DATA_WIDTH(32)) bus1 ();

  assign bus0.byte_valid_i = bv;
  assign bus0.byte_data_i  = bd;
  assign bus1.byte_valid_i = bv;
  assign bus1.byte_data_i  = bd;

  program_memory_loader #(
    .MEMORY_DEPTH (32),
    .DATA_WIDTH   (32),
    .BASE_ADDRESS (32'h0)
  ) dut0 (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .word_count_i (word_count),
    .bus          (bus0.slave),
    .busy_o       (busy0),
    .done_o       (done0),
    .error_o      (err0),
    .cpu_hold_o   (hold0)
  );

  program_memory_loader #(
    .MEMORY_DEPTH (32),
    .DATA_WIDTH   (32),
    .BASE_ADDRESS (BASE1)
  ) dut1 (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_i),
    .word_count_i (word_count),
    .bus          (bus1.slave),
    .busy_o       (busy1),
    .done_o       (done1),
    .error_o      (err1),
    .cpu_hold_o   (hold1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [CW-1:0] cnt;
    logic          exp_err;
    logic          exp_busy;
  } start_vec_t;

  wr_t         q0[$];
  wr_t         q1[$];
  logic [31:0] wbuf[32];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_write(input int id, input logic [31:0] a,
                           input logic [31:0] d, input logic rdy);
    wr_t e;
    if (id == 0 && q0.size() > 0) e = q0.pop_front();
    else if (id == 1 && q1.size() > 0) e = q1.pop_front();
    else begin
      tests++;
      fails++;
      $display("FAIL unexpected_write dut%0d: got addr %h data %h expected no write",
               id, a, d);
      return;
    end
    chk($sformatf("dut%0d write addr", id), a, e.addr);
    chk($sformatf("dut%0d write data", id), d, e.data);
    chk($sformatf("dut%0d ready in write", id), {31'b0, rdy}, 32'h0);
  endtask

  always @(negedge clk) begin
    if (bus0.mem_we_o)
      mon_write(0, bus0.mem_addr_o, bus0.mem_data_o, bus0.byte_ready_o);
    if (bus1.mem_we_o)
      mon_write(1, bus1.mem_addr_o, bus1.mem_data_o, bus1.byte_ready_o);
  end

  task automatic push_exp(input int idx, input logic [31:0] w);
    q0.push_back('{32'(idx * 4), w});
    q1.push_back('{BASE1 + 32'(idx * 4), w});
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    start_i    = 1'b1;
    word_count = n;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    bit acc;
    guard = 0;
    bv    = 1'b1;
    bd    = b;
    do begin
      acc = bus0.byte_ready_o;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 20);
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL byte_accept: got no ready in 20 cycles expected accept");
    end
    if (gap) begin
      bv = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic feed(input int n, input bit gap, input bit poke);
    for (int w = 0; w < n; w++) begin
      push_exp(w, wbuf[w]);
      for (int b = 0; b < 4; b++) begin
        if (poke && w == 0 && b == 1) begin
          start_i    = 1'b1;
          word_count = 6'd5;
        end
        send_byte(wbuf[w][31-8*b -: 8], gap);
        start_i = 1'b0;
      end
    end
    bv = 1'b0;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done0 && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("done0 reached", {31'b0, done0}, 32'h1);
    chk("done1 reached", {31'b0, done1}, 32'h1);
    chk("q0 drained", q0.size(), 32'h0);
    chk("q1 drained", q1.size(), 32'h0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, " flags0"},
        {26'b0, busy0, done0, err0, hold0, bus0.byte_ready_o, bus0.mem_we_o}, 0);
    chk({name, " flags1"},
        {26'b0, busy1, done1, err1, hold1, bus1.byte_ready_o, bus1.mem_we_o}, 0);
    chk({name, " addr0"}, bus0.mem_addr_o, 0);
    chk({name, " data0"}, bus0.mem_data_o, 0);
    chk({name, " addr1"}, bus1.mem_addr_o, 0);
    chk({name, " data1"}, bus1.mem_data_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    start_vec_t tab[3];
    int         cs;
    tab[0] = '{6'd0,  1'b1, 1'b0};
    tab[1] = '{6'd33, 1'b1, 1'b0};
    tab[2] = '{6'd63, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;

    // basic two-word load, bytes every cycle
    wbuf[0] = 32'h2008_0005;
    wbuf[1] = 32'h0109_5020;
    pulse_start(6'd2);
    cs = cyc;
    chk("s1 busy", {31'b0, busy0}, 32'h1);
    chk("s1 hold", {31'b0, hold0}, 32'h1);
    chk("s1 ready", {31'b0, bus0.byte_ready_o}, 32'h1);
    feed(2, 1'b0, 1'b0);
    chk("s1 done early", {31'b0, done0}, 32'h0);
    @(posedge clk);
    #1;
    chk("s1 done", {31'b0, done0}, 32'h1);
    chk("s1 done cycle", 32'(cyc - cs), 32'd10);
    chk("s1 hold released", {31'b0, hold0}, 32'h0);
    chk("s1 q0 drained", q0.size(), 32'h0);

    // illegal counts from IDLE
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    foreach (tab[i]) begin
      pulse_start(tab[i].cnt);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("tab%0d err", i), {31'b0, err0}, {31'b0, tab[i].exp_err});
      chk($sformatf("tab%0d err1", i), {31'b0, err1}, {31'b0, tab[i].exp_err});
      chk($sformatf("tab%0d busy", i), {31'b0, busy0}, {31'b0, tab[i].exp_busy});
      chk($sformatf("tab%0d ready", i), {31'b0, bus0.byte_ready_o}, 32'h0);
    end

    // valid toggling; start also clears the sticky error
    pulse_start(6'd2);
    chk("s3 err cleared", {31'b0, err0}, 32'h0);
    feed(2, 1'b1, 1'b0);
    wait_done();

    // full-depth load from DONE
    for (int i = 0; i < 32; i++) wbuf[i] = $urandom;
    pulse_start(6'd32);
    feed(32, 1'b0, 1'b0);
    wait_done();
    chk("s4 last addr0", bus0.mem_addr_o, 32'h0000_007C);
    chk("s4 last addr1", bus1.mem_addr_o, 32'h0040_007C);
    repeat (5) @(posedge clk);
    #1;
    chk("s4 stays done", {31'b0, done1}, 32'h1);

    // reset mid-word, then reload from index 0
    pulse_start(6'd2);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    bv    = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_zero("s5 reset");
    reset   = 1'b0;
    wbuf[0] = 32'hCAFE_F00D;
    pulse_start(6'd1);
    feed(1, 1'b0, 1'b0);
    wait_done();

    // start pulsed during RECV is ignored
    wbuf[0] = 32'h1111_2222;
    wbuf[1] = 32'h3333_4444;
    pulse_start(6'd2);
    feed(2, 1'b0, 1'b1);
    chk("s6 hold mid", {31'b0, hold0}, 32'h1);
    wait_done();
    chk("s6 hold off", {31'b0, hold0}, 32'h0);
    chk("s6 no err", {31'b0, err0}, 32'h0);
    repeat (8) @(posedge clk);
    #1;
    chk("s6 still done", {31'b0, done0}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
